// File: rtl/spi_flash_monitor.sv
// Passive SPI flash bus decoder (single/dual/quad) feeding a valid/ready byte FIFO; SPI_MON_TIMESTAMP_EN adds per-byte cycle stamps.
// Latency: a completed byte reaches out_valid SYNC_STAGES+1 clk edges after its last sclk rise reaches the pins; no backpressure to the bus, bytes hitting a full FIFO are dropped and flagged.
module spi_flash_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int IDX_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flash_sclk,
  input  logic             flash_csn,
  input  logic [3:0]       flash_d,
  input  logic [1:0]       lane_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [IDX_W-1:0] out_index,
  output logic             out_first,
`ifdef SPI_MON_TIMESTAMP_EN
  output logic [15:0]      out_stamp,
`endif
  output logic             busy,
  output logic [15:0]      txn_count,
  output logic             overflow,
  output logic             partial_err,
  input  logic             clear
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SKIP = 2'd1;
  localparam logic [1:0] ST_CMD  = 2'd2;
  localparam logic [1:0] ST_DATA = 2'd3;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
`ifdef SPI_MON_TIMESTAMP_EN
  localparam int ENT_W = 25 + IDX_W;
`else
  localparam int ENT_W = 9 + IDX_W;
`endif

  logic [SYNC_STAGES-1:0]      sclk_sync_q, sclk_sync_d, csn_sync_q, csn_sync_d;
  logic [SYNC_STAGES-1:0][3:0] d_sync_q, d_sync_d;
  logic [SYNC_STAGES:0]        live_q, live_d;
  logic                        prev_sclk_q, prev_csn_q;
  logic [1:0]                  state_q, state_d, mode_q, mode_d, eff_mode;
  logic [2:0]                  bit_cnt_q, bit_cnt_d;
  logic [6:0]                  shift_q, shift_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [15:0]                 txn_q, txn_d;
  logic                        ovf_q, ovf_d, part_q, part_d;
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]              cnt_q, cnt_d;
  logic [ENT_W-1:0]            mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]            wr_ent, head;
  logic                        sclk_s, csn_s, start_ev, end_ev, rise_ev;
  logic [3:0]                  d_s, step, bit_sum;
  logic [7:0]                  byte_nxt;
  logic                        push, push_first, txn_inc, part_set, pop, full, wr_en, drop;
`ifdef SPI_MON_TIMESTAMP_EN
  logic [15:0]                 stamp_q, stamp_d;
`endif

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign csn_s  = csn_sync_q[SYNC_STAGES-1];
  assign d_s    = d_sync_q[SYNC_STAGES-1];

  // live_q tracks which stages hold real bus samples since reset, so a csn
  // already low at reset release reads as SKIP rather than a fresh start.
  assign start_ev = prev_csn_q & ~csn_s & live_q[SYNC_STAGES];
  assign end_ev   = ~prev_csn_q & csn_s;
  assign rise_ev  = ~prev_sclk_q & sclk_s & ~csn_s;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], flash_sclk};
    csn_sync_d  = {csn_sync_q[SYNC_STAGES-2:0], flash_csn};
    d_sync_d    = {d_sync_q[SYNC_STAGES-2:0], flash_d};
    live_d      = {live_q[SYNC_STAGES-1:0], 1'b1};
  end

  always_comb begin
    eff_mode = (state_q == ST_CMD) ? 2'd0 : mode_q;
    case (eff_mode)
      2'd1:    begin step = 4'd2; byte_nxt = {shift_q[5:0], d_s[1:0]}; end
      2'd2:    begin step = 4'd4; byte_nxt = {shift_q[3:0], d_s}; end
      default: begin step = 4'd1; byte_nxt = {shift_q[6:0], d_s[0]}; end
    endcase
    bit_sum = {1'b0, bit_cnt_q} + step;
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    push       = 1'b0;
    push_first = 1'b0;
    txn_inc    = 1'b0;
    part_set   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ev) begin
          state_d   = ST_CMD;
          bit_cnt_d = 3'd0;
          idx_d     = '0;
          mode_d    = (lane_mode == 2'd3) ? 2'd0 : lane_mode;
        end else if (!csn_s) begin
          state_d = ST_SKIP;
        end
      end
      ST_SKIP: begin
        if (csn_s) state_d = ST_IDLE;
      end
      default: begin
        if (end_ev) begin
          state_d  = ST_IDLE;
          txn_inc  = 1'b1;
          part_set = (bit_cnt_q != 3'd0);
        end else if (rise_ev) begin
          shift_d   = byte_nxt[6:0];
          bit_cnt_d = bit_sum[2:0];
          if (bit_sum[3]) begin
            push       = 1'b1;
            push_first = (state_q == ST_CMD);
            state_d    = ST_DATA;
            if (idx_q != '1) idx_d = idx_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    pop      = out_valid & out_ready;
    full     = (cnt_q == FULL_CNT);
    wr_en    = push & (~full | pop);
    drop     = push & full & ~pop;
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q + {{PTR_W{1'b0}}, wr_en} - {{PTR_W{1'b0}}, pop};
    // A flag-setting event in the same cycle as clear takes priority.
    ovf_d    = (ovf_q & ~clear) | drop;
    part_d   = (part_q & ~clear) | part_set;
    txn_d    = (clear ? 16'd0 : txn_q) + {15'd0, txn_inc};
  end

`ifdef SPI_MON_TIMESTAMP_EN
  assign stamp_d = stamp_q + 16'd1;
  assign wr_ent  = {stamp_q, push_first, idx_q, byte_nxt};
`else
  assign wr_ent  = {push_first, idx_q, byte_nxt};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      csn_sync_q  <= '1;
      d_sync_q    <= '0;
      live_q      <= '0;
      prev_sclk_q <= 1'b0;
      prev_csn_q  <= 1'b1;
      state_q     <= ST_IDLE;
      mode_q      <= 2'd0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= '0;
      idx_q       <= '0;
      txn_q       <= '0;
      ovf_q       <= 1'b0;
      part_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
`ifdef SPI_MON_TIMESTAMP_EN
      stamp_q     <= '0;
`endif
    end else begin
      sclk_sync_q <= sclk_sync_d;
      csn_sync_q  <= csn_sync_d;
      d_sync_q    <= d_sync_d;
      live_q      <= live_d;
      prev_sclk_q <= sclk_s;
      prev_csn_q  <= csn_s;
      state_q     <= state_d;
      mode_q      <= mode_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      txn_q       <= txn_d;
      ovf_q       <= ovf_d;
      part_q      <= part_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
`ifdef SPI_MON_TIMESTAMP_EN
      stamp_q     <= stamp_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_ent;
  end

  assign head        = mem_q[rd_ptr_q];
  assign out_valid   = (cnt_q != '0);
  assign out_data    = out_valid ? head[7:0] : 8'd0;
  assign out_index   = out_valid ? head[8 +: IDX_W] : '0;
  assign out_first   = out_valid & head[8+IDX_W];
`ifdef SPI_MON_TIMESTAMP_EN
  assign out_stamp   = out_valid ? head[ENT_W-1 -: 16] : 16'd0;
`endif
  assign busy        = (state_q == ST_CMD) || (state_q == ST_DATA);
  assign txn_count   = txn_q;
  assign overflow    = ovf_q;
  assign partial_err = part_q;
endmodule

// File: tb/tb_spi_flash_monitor.sv
// Bench for spi_flash_monitor: transactions are described as byte lists; the model predicts pops, counters and flags from them.
module tb_spi_flash_monitor;
  localparam int IDX_W = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flash_sclk = 1'b0;
  logic             flash_csn = 1'b1;
  logic [3:0]       flash_d = 4'd0;
  logic [1:0]       lane_mode = 2'd0;
  logic             out_ready = 1'b0;
  logic             clear = 1'b0;
  logic             out_valid, out_first, busy, overflow, partial_err;
  logic [7:0]       out_data;
  logic [IDX_W-1:0] out_index;
  logic [15:0]      txn_count;
`ifdef SPI_MON_TIMESTAMP_EN
  logic [15:0]      out_stamp;
  logic [15:0]      cyc = 16'd0;
  logic [15:0]      vrise_cyc = 16'd0;
  logic             ov_seen = 1'b0;
`endif

  spi_flash_monitor #(.SYNC_STAGES(2), .FIFO_DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .flash_sclk(flash_sclk), .flash_csn(flash_csn),
    .flash_d(flash_d), .lane_mode(lane_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
    .out_first(out_first),
`ifdef SPI_MON_TIMESTAMP_EN
    .out_stamp(out_stamp),
`endif
    .busy(busy), .txn_count(txn_count), .overflow(overflow),
    .partial_err(partial_err), .clear(clear)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       first;
    logic [7:0] idx;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         rdy_mode = 0;   // 0 stalled, 1 always ready, 2 random
  int         stall_fill = 0;
  int         exp_txn = 0;
  logic       exp_partial = 1'b0;
  logic       exp_ovf = 1'b0;
  logic [1:0] cur_mode = 2'd0;
  int         cur_idx = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

`ifdef SPI_MON_TIMESTAMP_EN
  always @(posedge clk) cyc <= rst ? 16'd0 : cyc + 16'd1;
  initial forever begin
    @(negedge clk);
    if (out_valid && !ov_seen) vrise_cyc = cyc;
    ov_seen = out_valid;
  end
`endif

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Scoreboard: every accepted head must match the oldest predicted byte.
  initial forever begin
    exp_t e;
    int   pend;
    @(negedge clk);
    if (!rst && out_valid && out_ready) begin
      pend = exp_q.size();
      chk("pop_expected", 32'(pend != 0), 32'd1);
      if (pend != 0) begin
        e = exp_q.pop_front();
        chk("pop_data", {24'd0, out_data}, {24'd0, e.data});
        chk("pop_index", {24'd0, out_index}, {24'd0, e.idx});
        chk("pop_first", {31'd0, out_first}, {31'd0, e.first});
      end
    end
  end

  function automatic int lanes_of(input logic [1:0] m);
    case (m)
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 1;
    endcase
  endfunction

  task automatic sclk_pulse(input logic [3:0] d);
    flash_d = d;
    wait_clk($urandom_range(2, 4));
    flash_sclk = 1'b1;
    wait_clk($urandom_range(2, 4));
    flash_sclk = 1'b0;
  endtask

  // Sends the first n_rises lane groups of b, MSB first; idle lanes carry noise.
  task automatic send_lanes(input logic [7:0] b, input int lanes, input int n_rises);
    logic [3:0] d;
    for (int k = 0; k < n_rises; k++) begin
      d = 4'($urandom);
      case (lanes)
        1:       d[0] = b[7-k];
        2:       d[1:0] = b[7-2*k -: 2];
        default: d = b[7-4*k -: 4];
      endcase
      sclk_pulse(d);
    end
  endtask

  task automatic begin_txn(input logic [1:0] m);
    lane_mode = m;
    cur_mode = m;
    cur_idx = 0;
    flash_csn = 1'b0;
    wait_clk(3);
  endtask

  task automatic send_byte(input logic [7:0] b);
    exp_t e;
    int   lanes;
    lanes = (cur_idx == 0) ? 1 : lanes_of(cur_mode);
    e.first = (cur_idx == 0);
    e.idx = (cur_idx > 255) ? 8'd255 : 8'(cur_idx);
    e.data = b;
    if (rdy_mode == 0) begin
      if (stall_fill < DEPTH) begin
        exp_q.push_back(e);
        stall_fill++;
      end else begin
        exp_ovf = 1'b1;
      end
    end else begin
      exp_q.push_back(e);
    end
    send_lanes(b, lanes, 8 / lanes);
    cur_idx++;
  endtask

  task automatic send_tail(input int n);
    send_lanes(8'($urandom), (cur_idx == 0) ? 1 : lanes_of(cur_mode), n);
    exp_partial = 1'b1;
  endtask

  task automatic csn_rise();
    wait_clk(3);
    flash_csn = 1'b1;
    wait_clk(5);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 3000) begin
      wait_clk(1);
      guard++;
    end
    wait_clk(3);
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    chk("idle_valid", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic end_and_check(input string tag);
    csn_rise();
    exp_txn++;
    drain();
    chk({tag, "_txn_count"}, {16'd0, txn_count}, 32'(exp_txn));
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_partial"}, {31'd0, partial_err}, {31'd0, exp_partial});
    chk({tag, "_overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
  endtask

  task automatic do_clear();
    clear = 1'b1;
    wait_clk(1);
    clear = 1'b0;
    exp_partial = 1'b0;
    exp_ovf = 1'b0;
    exp_txn = 0;
    chk("clr_overflow", {31'd0, overflow}, 32'd0);
    chk("clr_partial", {31'd0, partial_err}, 32'd0);
    chk("clr_txn_count", {16'd0, txn_count}, 32'd0);
  endtask

  initial begin
    wait_clk(5);
    rst = 1'b0;
    wait_clk(1);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {24'd0, out_data}, 32'd0);
    chk("rst_index", {24'd0, out_index}, 32'd0);
    chk("rst_first", {31'd0, out_first}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_txn_count", {16'd0, txn_count}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_partial", {31'd0, partial_err}, 32'd0);
    rdy_mode = 2;

    begin_txn(2'd0);
    chk("busy_in_txn", {31'd0, busy}, 32'd1);
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h10); send_byte(8'h20);
    end_and_check("single");

    begin_txn(2'd2);
    send_byte(8'hEB); send_byte(8'h5A); send_byte(8'hC3);
    end_and_check("quad");

    begin_txn(2'd1);
    send_byte(8'h3B); send_byte(8'h9C);
    end_and_check("dual");

    // Stalled consumer: the fifth and sixth bytes are lost, later indices keep counting.
    rdy_mode = 0;
    stall_fill = 0;
    begin_txn(2'd0);
    for (int k = 1; k <= 6; k++) send_byte(8'(k * 8'h11));
    wait_clk(6);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    chk("ovf_head_valid", {31'd0, out_valid}, 32'd1);
    rdy_mode = 2;
    drain();
    send_byte(8'h77);
    end_and_check("ovf");
    do_clear();

    begin_txn(2'd0);
    send_byte(8'h0B); send_byte(8'h12);
    send_tail(5);
    end_and_check("partial");
    do_clear();

    for (int t = 0; t < 12; t++) begin
      logic [1:0] m;
      int         nb;
      int         ln;
      m = 2'($urandom_range(0, 3));
      nb = $urandom_range(0, 5);
      ln = lanes_of(m);
      begin_txn(m);
      for (int b = 0; b < nb; b++) send_byte(8'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        if (nb == 0) send_tail($urandom_range(1, 7));
        else send_tail($urandom_range(1, 8 / ln - 1));
      end
      end_and_check("rand");
      if (exp_partial) do_clear();
    end

    // Index saturates at 255 on long transfers.
    begin_txn(2'd2);
    for (int b = 0; b < 259; b++) send_byte(8'($urandom));
    end_and_check("sat");

    // Reset mid-command with csn held low: bus ignored until a fresh csn fall.
    begin_txn(2'd0);
    send_lanes(8'hA5, 1, 3);
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    exp_txn = 0;
    exp_partial = 1'b0;
    exp_ovf = 1'b0;
    send_lanes(8'hAB, 1, 8);
    wait_clk(10);
    chk("skip_no_valid", {31'd0, out_valid}, 32'd0);
    chk("skip_busy", {31'd0, busy}, 32'd0);
    chk("skip_txn_count", {16'd0, txn_count}, 32'd0);
    flash_csn = 1'b1;
    wait_clk(5);
    chk("skip_exit_txn_count", {16'd0, txn_count}, 32'd0);
    rdy_mode = 0;
    stall_fill = 0;
    wait_clk(2);
`ifdef SPI_MON_TIMESTAMP_EN
    chk("stamp_empty", {16'd0, out_stamp}, 32'd0);
`endif
    begin_txn(2'd0);
    send_byte(8'h9F);
    wait_clk(6);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
`ifdef SPI_MON_TIMESTAMP_EN
    chk("stamp_push", {16'd0, out_stamp}, {16'd0, vrise_cyc - 16'd1});
`endif
    rdy_mode = 2;
    end_and_check("post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
